urv_writeback: RTL

Final (W) stage of the uRV pipeline, directly downstream of the execute stage and of `urv_multiply`. It registers the retiring instruction, selects its result from the ALU value, the multiplier output or the data-memory load word, and aligns and sign-extends loads. It then drives the register-file write port. It also stalls the pipeline while a load is outstanding, bounds that wait with a timeout, and provides the two-level bypass (current W result and last written result) that the synchronous-read register file requires.

---
 rtl/urv_writeback.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/urv_writeback.sv
// urv_writeback: final pipeline stage of uRV. Registers the retiring
// instruction, selects and aligns its result, drives the register-file
// write port, stalls on outstanding loads (with a timeout) and provides
// the two-level bypass needed by the synchronous-read register file.
module urv_writeback #(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_lsb_i,
  input  logic [31:0] mult_result_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic        w_stall_req_o,
  output logic        w_load_err_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic [4:0]  w_bypass_rd_o,
  output logic [31:0] w_bypass_value_o,
  output logic        w_bypass_write_o,
  output logic [4:0]  w_bypass_last_rd_o,
  output logic [31:0] w_bypass_last_value_o,
  output logic        w_bypass_last_write_o
);

  localparam logic [1:0] SRC_MULT    = 2'd1;
  localparam logic [1:0] SRC_LOAD    = 2'd2;
  localparam logic [7:0] TIMEOUT_CNT = 8'(LOAD_TIMEOUT);

  typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;

  // Byte/halfword extraction with sign or zero extension; unknown funct3
  // values fall back to the full word.
  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [2:0]  fun,
                                             input logic [1:0]  lsb);
    logic [7:0]  b;
    logic [15:0] h;
    case (lsb)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lsb[1] ? word[31:16] : word[15:0];
    case (fun)
      3'b000:  align_load = {{24{b[7]}}, b};
      3'b001:  align_load = {{16{h[15]}}, h};
      3'b100:  align_load = {24'd0, b};
      3'b101:  align_load = {16'd0, h};
      default: align_load = word;
    endcase
  endfunction

  logic        w_valid;
  logic [4:0]  w_rd;
  logic        w_write;
  logic [1:0]  w_source;
  logic [2:0]  w_fun;
  logic [1:0]  w_lsb;
  logic [31:0] w_alu_value;

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;

  logic        last_write;
  logic [4:0]  last_rd;
  logic [31:0] last_value;

  logic        is_load;
  logic        timeout;
  logic        stall;
  logic        abort;
  logic [31:0] result;
  logic        rf_write;

  assign is_load = w_valid && (w_source == SRC_LOAD);
  assign timeout = (state == ST_WAIT) && (cnt == TIMEOUT_CNT);
  assign stall   = is_load && !dm_load_done_i && !timeout;
  assign abort   = is_load && !dm_load_done_i && timeout;

  // Result source selection; reserved source 3 behaves like the ALU.
  always_comb begin
    result = w_alu_value;
    case (w_source)
      SRC_MULT: result = mult_result_i;
      SRC_LOAD: result = align_load(dm_data_l_i, w_fun, w_lsb);
      default:  result = w_alu_value;
    endcase
  end

  assign rf_write = w_valid && w_write && (w_rd != 5'd0) && !stall && !abort;

  // W register: captures the X instruction whenever W is not stalled.
  // Fields only update for valid instructions so idle cycles keep the
  // write port quiet.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_valid     <= 1'b0;
      w_rd        <= 5'd0;
      w_write     <= 1'b0;
      w_source    <= 2'd0;
      w_fun       <= 3'd0;
      w_lsb       <= 2'd0;
      w_alu_value <= 32'd0;
    end else if (!stall) begin
      w_valid <= x_valid_i;
      if (x_valid_i) begin
        w_rd        <= x_rd_i;
        w_write     <= x_rd_write_i;
        w_source    <= x_rd_source_i;
        w_fun       <= x_fun_i;
        w_lsb       <= x_dm_addr_lsb_i;
        w_alu_value <= x_rd_value_i;
      end
    end
  end

  // Load-wait FSM state and wait counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; the counter holds the number of stall cycles
  // already spent on the current load, so it reaches LOAD_TIMEOUT on
  // the cycle after the last allowed stall.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_next = 8'd0;
        if (stall) begin
          state_next = ST_WAIT;
          cnt_next   = 8'd1;
        end
      end
      default: begin
        if (dm_load_done_i || timeout) begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
    endcase
  end

  // Last-written result, taken from the rf port every cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_write <= 1'b0;
      last_rd    <= 5'd0;
      last_value <= 32'd0;
    end else begin
      last_write <= rf_write;
      last_rd    <= w_rd;
      last_value <= result;
    end
  end

  assign w_stall_req_o         = stall;
  assign w_load_err_o          = abort;
  assign rf_rd_o               = w_rd;
  assign rf_rd_value_o         = result;
  assign rf_rd_write_o         = rf_write;
  assign w_bypass_rd_o         = w_rd;
  assign w_bypass_value_o      = result;
  assign w_bypass_write_o      = rf_write;
  assign w_bypass_last_rd_o    = last_rd;
  assign w_bypass_last_value_o = last_value;
  assign w_bypass_last_write_o = last_write;

endmodule
